// File: rtl/reg_file_pkg.sv
// Shared core constants for the RV32I integer register file.
//   RF_WIDTH   : data width of one architectural register
//   RF_ADDR_W  : register index width (depth = 2**RF_ADDR_W)
//   abi_reg_e  : ABI names for the 32 integer registers, used by the
//                decoder and benches to avoid bare magic indices.
package reg_file_pkg;

  localparam int RF_WIDTH  = 32;
  localparam int RF_ADDR_W = 5;

  typedef enum logic [RF_ADDR_W-1:0] {
    ZERO = 5'd0,  RA  = 5'd1,  SP  = 5'd2,  GP  = 5'd3,
    TP   = 5'd4,  T0  = 5'd5,  T1  = 5'd6,  T2  = 5'd7,
    S0   = 5'd8,  S1  = 5'd9,  A0  = 5'd10, A1  = 5'd11,
    A2   = 5'd12, A3  = 5'd13, A4  = 5'd14, A5  = 5'd15,
    A6   = 5'd16, A7  = 5'd17, S2  = 5'd18, S3  = 5'd19,
    S4   = 5'd20, S5  = 5'd21, S6  = 5'd22, S7  = 5'd23,
    S8   = 5'd24, S9  = 5'd25, S10 = 5'd26, S11 = 5'd27,
    T3   = 5'd28, T4  = 5'd29, T5  = 5'd30, T6  = 5'd31
  } abi_reg_e;

endpackage

// File: rtl/reg_file.sv
// 32-entry integer register file for the single-cycle RV32I core.
// Two combinational read ports feed the ALU (RD1 -> operand A, RD2 ->
// operand B / store data); one synchronous write port takes the ALU result
// or load data. x0 has no storage and always reads zero.
//
// Ports:
//   clk   in   core clock, writes on rising edge
//   rst_n in   asynchronous active-low reset, clears every register
//   A1/A2 in   read addresses (rs1 / rs2)
//   RD1/RD2 out read data, optionally bypassed from the write port
//   WE3   in   write enable
//   A3    in   write address (rd); writes to x0 are discarded
//   WD3   in   write data
//   DbgA  in   debug read address
//   DbgD  out  debug read data, always the stored value (never bypassed)
module reg_file
  import reg_file_pkg::*;
#(
  parameter int Width  = RF_WIDTH,
  parameter int AddrW  = RF_ADDR_W,
  parameter bit Bypass = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AddrW-1:0] A1,
  input  logic [AddrW-1:0] A2,
  output logic [Width-1:0] RD1,
  output logic [Width-1:0] RD2,
  input  logic             WE3,
  input  logic [AddrW-1:0] A3,
  input  logic [Width-1:0] WD3,
  input  logic [AddrW-1:0] DbgA,
  output logic [Width-1:0] DbgD
);

  localparam int Depth = 2 ** AddrW;

  // Storage starts at index 1: x0 is synthesised as a constant zero.
  logic [Width-1:0] regs_q [1:Depth-1];
  logic [Width-1:0] regs_d [1:Depth-1];

  always_comb begin
    regs_d = regs_q;
    if (WE3 && (A3 != '0)) begin
      regs_d[A3] = WD3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Single read-port mux shared by all three read ports. The bypass compare
  // excludes x0 implicitly because address zero short-circuits to zero first.
  function automatic logic [Width-1:0] read_port(input logic [AddrW-1:0] addr,
                                                 input logic             byp_en);
    logic [Width-1:0] data;
    data = '0;
    if (addr != '0) begin
      if (byp_en && WE3 && (A3 == addr)) begin
        data = WD3;
      end else begin
        data = regs_q[addr];
      end
    end
    return data;
  endfunction

  always_comb begin
    RD1  = read_port(A1, Bypass);
    RD2  = read_port(A2, Bypass);
    DbgD = read_port(DbgA, 1'b0);
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file. Two instances share all inputs:
// u_byp has the write-to-read bypass enabled, u_nob has it disabled.
module tb_reg_file;
  import reg_file_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [4:0]  a1, a2, a3, dbga;
  logic        we3;
  logic [31:0] wd3;
  logic [31:0] rd1_b, rd2_b, dbg_b;
  logic [31:0] rd1_n, rd2_n, dbg_n;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  reg_file #(.Width(32), .AddrW(5), .Bypass(1'b1)) u_byp (
    .clk(clk), .rst_n(rst_n), .A1(a1), .A2(a2), .RD1(rd1_b), .RD2(rd2_b),
    .WE3(we3), .A3(a3), .WD3(wd3), .DbgA(dbga), .DbgD(dbg_b)
  );

  reg_file #(.Width(32), .AddrW(5), .Bypass(1'b0)) u_nob (
    .clk(clk), .rst_n(rst_n), .A1(a1), .A2(a2), .RD1(rd1_n), .RD2(rd2_n),
    .WE3(we3), .A3(a3), .WD3(wd3), .DbgA(dbga), .DbgD(dbg_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one write at a falling edge, let the rising edge commit it, and
  // return at the following falling edge with WE3 deasserted.
  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    we3 = 1'b1;
    a3  = addr;
    wd3 = data;
    @(negedge clk);
    we3 = 1'b0;
  endtask

  function automatic logic [31:0] sweep_pat(input int i);
    return (i == 0) ? 32'h0 : 32'(i) * 32'h01010101;
  endfunction

  initial begin
    rst_n = 1'b0;
    we3   = 1'b0;
    a1    = '0;
    a2    = '0;
    a3    = '0;
    wd3   = '0;
    dbga  = '0;

    // Reset state; a write requested while reset is held must be ignored.
    repeat (2) @(negedge clk);
    check("rst_x1_byp", dbg_b, 32'h0);
    we3  = 1'b1;
    a3   = S1;
    wd3  = 32'hCAFEF00D;
    dbga = S1;
    @(posedge clk); #1;
    check("rst_we_ignored_byp", dbg_b, 32'h0);
    check("rst_we_ignored_nob", dbg_n, 32'h0);
    @(negedge clk);
    we3   = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release_x9", dbg_b, 32'h0);

    // Basic write then read on both ports.
    write_reg(T2, 32'd4000);
    a1 = T2;
    a2 = T2;
    #1;
    check("wr7_rd1_byp", rd1_b, 32'd4000);
    check("wr7_rd2_byp", rd2_b, 32'd4000);
    check("wr7_rd1_nob", rd1_n, 32'd4000);
    write_reg(S0, 32'd4001);
    a1 = T2;
    a2 = S0;
    #1;
    check("wr8_rd1", rd1_b, 32'd4000);
    check("wr8_rd2", rd2_b, 32'd4001);
    check("wr8_rd2_nob", rd2_n, 32'd4001);

    // x0 guard, including no bypass of a write aimed at x0.
    @(negedge clk);
    we3  = 1'b1;
    a3   = ZERO;
    wd3  = 32'hFFFFFFFF;
    a1   = ZERO;
    dbga = ZERO;
    #1;
    check("x0_no_bypass", rd1_b, 32'h0);
    @(negedge clk);
    we3 = 1'b0;
    #1;
    check("x0_rd1_byp", rd1_b, 32'h0);
    check("x0_rd1_nob", rd1_n, 32'h0);
    check("x0_dbg", dbg_b, 32'h0);

    // Same-cycle read of the register being written.
    write_reg(GP, 32'd10);
    we3  = 1'b1;
    a3   = GP;
    wd3  = 32'd25;
    a1   = GP;
    a2   = GP;
    dbga = GP;
    #1;
    check("byp_rd1_pre", rd1_b, 32'd25);
    check("byp_rd2_pre", rd2_b, 32'd25);
    check("byp_dbg_pre", dbg_b, 32'd10);
    check("nob_rd1_pre", rd1_n, 32'd10);
    check("nob_rd2_pre", rd2_n, 32'd10);
    check("nob_dbg_pre", dbg_n, 32'd10);
    @(posedge clk); #1;
    check("byp_dbg_post", dbg_b, 32'd25);
    check("nob_rd1_post", rd1_n, 32'd25);
    check("nob_dbg_post", dbg_n, 32'd25);
    @(negedge clk);
    we3 = 1'b0;

    // Asynchronous reset pulse of 3 ns between edges clears storage at once.
    write_reg(T0, 32'hDEADBEEF);
    dbga = T0;
    #1;
    check("x5_before_rst", dbg_b, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    check("x5_async_clr_byp", dbg_b, 32'h0);
    check("x5_async_clr_nob", dbg_n, 32'h0);
    dbga = T2;
    #1;
    check("x7_async_clr", dbg_b, 32'h0);
    #1;
    rst_n = 1'b1;

    // Reset asserted across a write edge: the write is lost.
    @(negedge clk);
    we3  = 1'b1;
    a3   = T1;
    wd3  = 32'h12345678;
    dbga = T1;
    #2;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midwrite_in_rst", dbg_b, 32'h0);
    @(negedge clk);
    we3 = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    check("midwrite_lost_byp", dbg_b, 32'h0);
    check("midwrite_lost_nob", dbg_n, 32'h0);

    // Full sweep, then idle cycles with random address/data and WE3 low.
    for (int i = 0; i < 32; i++) begin
      write_reg(5'(i), 32'(i) * 32'h01010101);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      we3 = 1'b0;
      a3  = 5'($urandom_range(0, 31));
      wd3 = $urandom;
    end
    @(negedge clk);
    a3 = '0;
    for (int i = 0; i < 32; i++) begin
      a1   = 5'(i);
      a2   = 5'(31 - i);
      dbga = 5'(i);
      #1;
      check($sformatf("sweep_rd1_x%0d", i), rd1_b, sweep_pat(i));
      check($sformatf("sweep_rd2_x%0d", 31 - i), rd2_b, sweep_pat(31 - i));
      check($sformatf("sweep_dbg_x%0d", i), dbg_b, sweep_pat(i));
      check($sformatf("sweep_nob_x%0d", i), rd1_n, sweep_pat(i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
